// File: rtl/pa_fdsu_pkg.sv
// Shared constants, helpers and beat type for the FDSU normaliser datapath.
package pa_fdsu_pkg;

    localparam int FDSU_FRAC_W = 52;
    localparam int FDSU_EXP_W  = 13;

    // Ceiling log2, usable in constant expressions.
    function automatic int fdsu_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int FDSU_LZ_W = fdsu_clog2(FDSU_FRAC_W);

    // One in-flight normaliser beat at the default FDSU widths.
    typedef struct packed {
        logic [FDSU_FRAC_W-1:0] frac;
        logic [FDSU_LZ_W-1:0]   lz;
        logic [FDSU_EXP_W-1:0]  exp;
        logic                   cnt_only;
        logic                   zero;
    } norm_beat_t;

endpackage

// File: rtl/pa_fdsu_norm_step.sv
// Combinational slice of the leading-one barrel: steps FIRST_K down to LAST_K.
// Each step shifts left by 2^k when the top 2^k bits are all zero and adds 2^k
// to the running leading-zero count.
module pa_fdsu_norm_step
    import pa_fdsu_pkg::*;
#(
    parameter int FRAC_W  = FDSU_FRAC_W,
    parameter int LZ_W    = FDSU_LZ_W,
    parameter int FIRST_K = 5,
    parameter int LAST_K  = 3
) (
    input  logic [FRAC_W-1:0] frac_i,
    input  logic [LZ_W-1:0]   lz_i,
    output logic [FRAC_W-1:0] frac_o,
    output logic [LZ_W-1:0]   lz_o
);

    localparam int N_STEP = FIRST_K - LAST_K + 1;

    genvar gi;
    generate
        for (gi = 0; gi < N_STEP; gi++) begin : g_step
            localparam int SH = 1 << (FIRST_K - gi);
            logic [FRAC_W-1:0] frac_cur;
            logic [FRAC_W-1:0] frac_nxt;
            logic [LZ_W-1:0]   lz_cur;
            logic [LZ_W-1:0]   lz_nxt;
            logic              top_zero;

            if (gi == 0) begin : g_head
                assign frac_cur = frac_i;
                assign lz_cur   = lz_i;
            end else begin : g_chain
                assign frac_cur = g_step[gi-1].frac_nxt;
                assign lz_cur   = g_step[gi-1].lz_nxt;
            end

            assign top_zero = ~|frac_cur[FRAC_W-1 -: SH];
            assign frac_nxt = top_zero ? (frac_cur << SH) : frac_cur;
            assign lz_nxt   = top_zero ? (lz_cur + LZ_W'(SH)) : lz_cur;
        end
    endgenerate

    assign frac_o = g_step[N_STEP-1].frac_nxt;
    assign lz_o   = g_step[N_STEP-1].lz_nxt;

endmodule

// File: rtl/pa_fdsu_norm_pipe.sv
// Pipelined leading-one normaliser: left-justifies the fraction, reports
// -(leading zeros) and the adjusted exponent, with valid/ready and flush.
module pa_fdsu_norm_pipe
    import pa_fdsu_pkg::*;
#(
    parameter int FRAC_W   = FDSU_FRAC_W,
    parameter int EXP_W    = FDSU_EXP_W,
    parameter int PIPE_STG = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [FRAC_W-1:0] in_frac_i,
    input  logic [EXP_W-1:0]  in_exp_i,
    input  logic              in_cnt_only_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [FRAC_W-1:0] out_frac_o,
    output logic [EXP_W-1:0]  out_bin_val_o,
    output logic [EXP_W-1:0]  out_exp_o,
    output logic              out_zero_o
);

    localparam int S         = fdsu_clog2(FRAC_W);
    localparam int LZ_W      = S;
    localparam int STEP_BASE = S / PIPE_STG;
    localparam int STEP_REM  = S % PIPE_STG;

    // raw keeps the unshifted fraction so count-only beats can bypass the barrel.
    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        logic [FRAC_W-1:0] raw;
        logic [LZ_W-1:0]   lz;
        logic [EXP_W-1:0]  exp;
        logic              cnt_only;
        logic              zero;
    } beat_t;

    beat_t               beat_q  [PIPE_STG];
    beat_t               beat_d  [PIPE_STG];
    beat_t               stg_in  [PIPE_STG];
    beat_t               stg_out [PIPE_STG];
    logic [PIPE_STG-1:0] v_q;
    logic [PIPE_STG-1:0] v_d;
    logic [PIPE_STG-1:0] stg_rdy;
    logic [PIPE_STG-1:0] up_v;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STG; gi++) begin : g_stage
            // Earlier stages take the extra barrel step when S does not divide evenly.
            localparam int N_STEP  = STEP_BASE + ((gi < STEP_REM) ? 1 : 0);
            localparam int OFF     = gi * STEP_BASE + ((gi < STEP_REM) ? gi : STEP_REM);
            localparam bit IS_LAST = (gi == PIPE_STG - 1);
            logic [FRAC_W-1:0] frac_sh;
            logic [LZ_W-1:0]   lz_sh;

            if (gi == 0) begin : g_entry
                assign stg_in[gi] = '{frac: in_frac_i, raw: in_frac_i, lz: LZ_W'(0),
                                      exp: in_exp_i, cnt_only: in_cnt_only_i,
                                      zero: ~|in_frac_i};
            end else begin : g_link
                assign stg_in[gi] = beat_q[gi-1];
            end

            pa_fdsu_norm_step #(
                .FRAC_W (FRAC_W),
                .LZ_W   (LZ_W),
                .FIRST_K(S - 1 - OFF),
                .LAST_K (S - OFF - N_STEP)
            ) u_step (
                .frac_i(stg_in[gi].frac),
                .lz_i  (stg_in[gi].lz),
                .frac_o(frac_sh),
                .lz_o  (lz_sh)
            );

            assign stg_out[gi] = '{
                frac:     (IS_LAST && stg_in[gi].cnt_only) ? stg_in[gi].raw : frac_sh,
                raw:      stg_in[gi].raw,
                lz:       lz_sh,
                exp:      stg_in[gi].exp,
                cnt_only: stg_in[gi].cnt_only,
                zero:     stg_in[gi].zero
            };
        end
    endgenerate

    // Ready chain from the output back, then per-stage load with bubble collapse and flush.
    always_comb begin
        stg_rdy[PIPE_STG-1] = ~v_q[PIPE_STG-1] | out_ready_i;
        for (int j = PIPE_STG - 2; j >= 0; j--) begin
            stg_rdy[j] = ~v_q[j] | stg_rdy[j+1];
        end
        up_v[0] = in_valid_i;
        for (int j = 1; j < PIPE_STG; j++) begin
            up_v[j] = v_q[j-1];
        end
        for (int j = 0; j < PIPE_STG; j++) begin
            v_d[j]    = v_q[j];
            beat_d[j] = beat_q[j];
            if (stg_rdy[j]) begin
                v_d[j] = up_v[j];
                if (up_v[j]) begin
                    beat_d[j] = stg_out[j];
                end
            end
            if (flush_i) begin
                v_d[j] = 1'b0;
            end
        end
    end

    // Stage registers; reset clears data too so outputs start at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int j = 0; j < PIPE_STG; j++) begin
                beat_q[j] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int j = 0; j < PIPE_STG; j++) begin
                beat_q[j] <= beat_d[j];
            end
        end
    end

    // A zero fraction runs every barrel step, so its count is forced to FRAC_W here.
    logic [EXP_W-1:0] lz_ext;
    assign lz_ext = beat_q[PIPE_STG-1].zero ? EXP_W'(FRAC_W) : EXP_W'(beat_q[PIPE_STG-1].lz);

    assign in_ready_o    = stg_rdy[0];
    assign out_valid_o   = v_q[PIPE_STG-1];
    assign out_frac_o    = beat_q[PIPE_STG-1].frac;
    assign out_zero_o    = beat_q[PIPE_STG-1].zero;
    assign out_bin_val_o = -lz_ext;
    assign out_exp_o     = beat_q[PIPE_STG-1].exp + out_bin_val_o;

endmodule
